seg_scan_reader: RTL

//  Receive end of the multiplexed 4-digit 7-segment display bus: samples active-low

---
 rtl/seg_scan_reader_pkg.sv | 52 +++++
 rtl/seg7_to_hex.sv | 35 +++
 rtl/seg_scan_reader.sv | 124 ++++++++++++
 3 files changed

// File: rtl/seg_scan_reader_pkg.sv
// Shared constants and small types for the 7-segment scan reader.
// Segment codes are active-low in {a,b,c,d,e,f,g} order.
package seg_scan_reader_pkg;

  localparam logic [6:0] SEG_0 = 7'b0000001;
  localparam logic [6:0] SEG_1 = 7'b1001111;
  localparam logic [6:0] SEG_2 = 7'b0010010;
  localparam logic [6:0] SEG_3 = 7'b0000110;
  localparam logic [6:0] SEG_4 = 7'b1001100;
  localparam logic [6:0] SEG_5 = 7'b0100100;
  localparam logic [6:0] SEG_6 = 7'b0100000;
  localparam logic [6:0] SEG_7 = 7'b0001111;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0000100;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b1100000;
  localparam logic [6:0] SEG_C = 7'b1110010;
  localparam logic [6:0] SEG_D = 7'b1000010;
  localparam logic [6:0] SEG_E = 7'b0110000;
  localparam logic [6:0] SEG_F = 7'b0111000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] AN_D0 = 4'b1110;
  localparam logic [3:0] AN_D1 = 4'b1101;
  localparam logic [3:0] AN_D2 = 4'b1011;
  localparam logic [3:0] AN_D3 = 4'b0111;

  typedef struct packed {
    logic       ok;
    logic [1:0] idx;
  } an_sel_t;

  typedef struct packed {
    logic       invalid;
    logic [3:0] nib;
  } hex_t;

  // Blanking and multi-low strobes are not a digit.
  function automatic an_sel_t an_select(input logic [3:0] a);
    an_sel_t s;
    s = '0;
    unique case (a)
      AN_D0:   s = '{ok: 1'b1, idx: 2'd0};
      AN_D1:   s = '{ok: 1'b1, idx: 2'd1};
      AN_D2:   s = '{ok: 1'b1, idx: 2'd2};
      AN_D3:   s = '{ok: 1'b1, idx: 2'd3};
      default: s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational 7-segment pattern to hex nibble decoder.
// Unknown patterns decode to nibble 0 with invalid set.
module seg7_to_hex
  import seg_scan_reader_pkg::*;
(
  input  logic [6:0] led_i,
  output logic [3:0] nibble_o,
  output logic       invalid_o
);

  always_comb begin
    nibble_o  = 4'h0;
    invalid_o = 1'b0;
    unique case (led_i)
      SEG_0:   nibble_o = 4'h0;
      SEG_1:   nibble_o = 4'h1;
      SEG_2:   nibble_o = 4'h2;
      SEG_3:   nibble_o = 4'h3;
      SEG_4:   nibble_o = 4'h4;
      SEG_5:   nibble_o = 4'h5;
      SEG_6:   nibble_o = 4'h6;
      SEG_7:   nibble_o = 4'h7;
      SEG_8:   nibble_o = 4'h8;
      SEG_9:   nibble_o = 4'h9;
      SEG_A:   nibble_o = 4'hA;
      SEG_B:   nibble_o = 4'hB;
      SEG_C:   nibble_o = 4'hC;
      SEG_D:   nibble_o = 4'hD;
      SEG_E:   nibble_o = 4'hE;
      SEG_F:   nibble_o = 4'hF;
      default: invalid_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg_scan_reader.sv
// Receive side of a multiplexed 4-digit 7-segment bus:
// settles each digit, decodes it and assembles 16-bit frames.
module seg_scan_reader
  import seg_scan_reader_pkg::*;
#(
  parameter int SETTLE_CYCLES = 16,
  parameter int SYNC_STAGES   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  an,
  input  logic [6:0]  led,
  output logic [15:0] value,
  output logic [3:0]  digit_err,
  output logic        frame_valid,
  output logic        frame_err
);

  localparam int CW =
    (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX =
    CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ARM =
    CW'(SETTLE_CYCLES - 2);

  logic [SYNC_STAGES-1:0][3:0] an_sync_q;
  logic [SYNC_STAGES-1:0][6:0] led_sync_q;

  logic [3:0]       an_s;
  logic [6:0]       led_s;
  logic [10:0]      pair;
  logic [10:0]      prev_q;
  logic [CW-1:0]    cnt_q, cnt_d;
  an_sel_t          sel;
  logic             stable;
  logic             capture;
  hex_t             dec;

  logic [3:0][3:0]  slot_q, slot_d;
  logic [3:0]       err_q, err_d;
  logic [3:0]       bmp_q, bmp_d;
  logic             done;

  logic [15:0]      value_q;
  logic [3:0]       digit_err_q;
  logic             frame_valid_q;
  logic             frame_err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      an_sync_q  <= '0;
      led_sync_q <= '0;
    end else begin
      an_sync_q  <= {an_sync_q[SYNC_STAGES-2:0], an};
      led_sync_q <= {led_sync_q[SYNC_STAGES-2:0], led};
    end
  end

  assign an_s  = an_sync_q[SYNC_STAGES-1];
  assign led_s = led_sync_q[SYNC_STAGES-1];
  assign pair  = {an_s, led_s};
  assign sel   = an_select(an_s);

  seg7_to_hex u_dec (
    .led_i     (led_s),
    .nibble_o  (dec.nib),
    .invalid_o (dec.invalid)
  );

  always_comb begin
    stable  = (pair == prev_q);
    capture = 1'b0;
    cnt_d   = '0;
    if (sel.ok && stable) begin
      // Saturate so a held digit is captured only once.
      cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
      capture = (cnt_q == CNT_ARM);
    end
  end

  always_comb begin
    done   = (bmp_q == 4'hF);
    slot_d = slot_q;
    err_d  = err_q;
    bmp_d  = done ? 4'h0 : bmp_q;
    if (capture) begin
      slot_d[sel.idx] = dec.nib;
      err_d[sel.idx]  = dec.invalid;
      bmp_d[sel.idx]  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q        <= '0;
      cnt_q         <= '0;
      slot_q        <= '0;
      err_q         <= '0;
      bmp_q         <= '0;
      value_q       <= '0;
      digit_err_q   <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      prev_q        <= pair;
      cnt_q         <= cnt_d;
      slot_q        <= slot_d;
      err_q         <= err_d;
      bmp_q         <= bmp_d;
      frame_valid_q <= done;
      if (done) begin
        value_q     <= slot_q;
        digit_err_q <= err_q;
        frame_err_q <= |err_q;
      end
    end
  end

  assign value       = value_q;
  assign digit_err   = digit_err_q;
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;

endmodule
